register_status_table: RTL
==========================

# register_status_table

Parametrised register-status scoreboard for the out-of-order issue stage. Tracks, per architectural register, whether a result is outstanding and which functional unit and reservation row will produce it. Issue sets an entry. A result broadcast clears every entry whose tag still matches. Several decode-side read ports observe the table asynchronously. Successor to the fixed two-port, 32-entry scoreboard, adding completion clearing, flush and a pending-entry count.

## Interface
Parameters:
- NREGS, 32, number of architectural registers (power of two, ≥2); ADDR_W = $clog2(NREGS)
- NREAD, 2, number of asynchronous read ports
- UNIT_W, 2, functional-unit id width
- ROW_W, 5, reservation-row id width; tag = {unit,row}, TAG_W = UNIT_W+ROW_W

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears the table
- flush  in  1  clear all entries (mispredict/exception)
- alloc_valid  in  1  issue writes an entry this cycle
- alloc_addr  in  ADDR_W  destination register
- alloc_unit  in  UNIT_W  producing unit
- alloc_row  in  ROW_W  producing row
- cmp_valid  in  1  result broadcast this cycle
- cmp_unit  in  UNIT_W  broadcasting unit
- cmp_row  in  ROW_W  broadcasting row
- rd_addr  in  NREAD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_pending  out  NREAD  pending flag per port
- rd_unit  out  NREAD*UNIT_W  producing unit per port
- rd_row  out  NREAD*ROW_W  producing row per port
- pending_count  out  ADDR_W+1  number of pending entries

## Operation
- Entry state: pending bit, unit and row fields.
- Register 0 is hardwired:
  - never pending
  - alloc to address 0 is ignored
  - reads of address 0 return pending=0, unit=0, row=0
- Alloc (alloc_valid, addr≠0): at the next edge the entry becomes pending=1 with the given tag, overwriting any older tag.
- Complete (cmp_valid):
  - At the next edge every pending entry whose stored tag equals {cmp_unit,cmp_row} is cleared.
  - Entries holding a different tag are untouched; the register was re-allocated to a later producer.
- Priority per entry in one cycle: reset > flush > alloc > complete.
  - alloc and complete to the same register: the alloc tag is stored and the entry remains pending, even if the completion matched the old tag.
- Flush: all pending bits clear at the next edge. A same-cycle alloc is dropped.
- Cleared entries keep their unit/row fields; only the pending bit is cleared.
- Read ports are purely combinational from the registered table, except for the bypass described in Configuration.
  - With pending=0, rd_unit/rd_row show the stale stored fields.
  - The verifier checks unit/row only when pending=1.
- pending_count is registered and equals the popcount of the table state after the same edge. It is always ≤ NREGS-1.

## Timing
- After reset (and after flush): all pending=0, unit/row fields=0, pending_count=0.
  - rd_pending=0 on every port.
  - Without bypass, rd_unit and rd_row read 0.
- Alloc in cycle N is visible on read ports in cycle N+1 (after edge N).
- Complete in cycle N clears the entry from cycle N+1.
- pending_count reflects edge N's updates in cycle N+1.
- Completion of a tag matching several entries clears all of them in the same edge, and pending_count drops by that many.
- reset asserted mid-operation overrides every other input in that cycle.

## Configuration
- REGSTAT_BYPASS_EN defined:
  - A read port whose addressed entry is pending and matches an active same-cycle completion reports pending=0 in that cycle.
  - The alloc path is not bypassed; an alloc still becomes visible next cycle.
- REGSTAT_BYPASS_EN undefined: read ports show registered state only, and the completion becomes visible one cycle later.
- pending_count is identical in both builds.

## Structure
- Shared package regstat_pkg:
  - default NREGS, UNIT_W and ROW_W constants
  - functional-unit id localparams: UNIT_ALU=0, UNIT_MEM=1, UNIT_MUL=2, UNIT_BR=3
  - tag struct/width helper
- One natural sub-module: regstat_entry, holding one entry's pending bit, fields, tag compare and priority logic.
  - Instantiated NREGS-1 times by generate.
  - Register 0 is a constant.
- Read muxes, bypass and popcount stay in the top level.

## Test plan
- Reset with random inputs held → every read port reports pending=0, pending_count=0 throughout and one cycle after release.
- Alloc r4 unit=1 row=3, read r4 on port 0 → pending=1 unit=1 row=3 from the next cycle, pending_count=1; alloc r0 → r0 reads pending=0, count unchanged.
- Alloc r4 tag(1,3), then r4 tag(2,7), then complete (1,3) → r4 stays pending with unit=2 row=7; complete (2,7) → cleared next cycle, count=0.
- Alloc r5 and r9 both with tag(0,1), complete (0,1) → both clear at the same edge, count 2→0; same-cycle alloc r5 tag(3,2) with complete (0,1) → r5 pending with (3,2).
- Count=3, assert flush together with alloc r7 → next cycle all pending=0, r7 not allocated, count=0.
- Bypass build: r6 pending tag(1,4), complete (1,4) while port 1 reads r6 → rd_pending=0 in that cycle. Non-bypass build → rd_pending=1 in that cycle, 0 the next.

Source files
------------

// File: rtl/regstat_pkg.sv
// Shared definitions for the register status table.
// Optional feature macro: REGSTAT_BYPASS_EN (same-cycle completion bypass).
package regstat_pkg;

    localparam int NREGS_DEF  = 32;
    localparam int UNIT_W_DEF = 2;
    localparam int ROW_W_DEF  = 5;

    localparam logic [UNIT_W_DEF-1:0] UNIT_ALU = 2'd0;
    localparam logic [UNIT_W_DEF-1:0] UNIT_MEM = 2'd1;
    localparam logic [UNIT_W_DEF-1:0] UNIT_MUL = 2'd2;
    localparam logic [UNIT_W_DEF-1:0] UNIT_BR  = 2'd3;

    typedef struct packed {
        logic [UNIT_W_DEF-1:0] unit;
        logic [ROW_W_DEF-1:0]  row;
    } regstat_tag_t;

    function automatic int tag_width(input int unit_w, input int row_w);
        return unit_w + row_w;
    endfunction

endpackage

// File: rtl/regstat_entry.sv
// One scoreboard entry: pending bit, producer tag, and the
// reset > flush > alloc > complete priority resolution.
module regstat_entry
    import regstat_pkg::*;
#(
    parameter int UNIT_W = UNIT_W_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int TAG_W  = tag_width(UNIT_W, ROW_W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_hit,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             cmp_valid,
    input  logic [TAG_W-1:0] cmp_tag,
    output logic             pending,
    output logic             pending_nxt,
    output logic [TAG_W-1:0] tag
);

    logic [TAG_W-1:0] tag_nxt;

    // Next-state for this entry; also feeds the top-level popcount.
    always_comb begin
        pending_nxt = pending;
        tag_nxt     = tag;
        if (reset || flush) begin
            pending_nxt = 1'b0;
            tag_nxt     = '0;
        end else if (alloc_hit) begin
            pending_nxt = 1'b1;
            tag_nxt     = alloc_tag;
        end else if (cmp_valid && pending && (tag == cmp_tag)) begin
            pending_nxt = 1'b0;
        end
    end

    // Entry state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
            tag     <= '0;
        end else begin
            pending <= pending_nxt;
            tag     <= tag_nxt;
        end
    end

endmodule

// File: rtl/register_status_table.sv
// Register status scoreboard: per-register producer tracking with
// combinational read ports and a registered pending count.
// Optional feature macro: REGSTAT_BYPASS_EN.
module register_status_table
    import regstat_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int UNIT_W = UNIT_W_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int ADDR_W = $clog2(NREGS),
    parameter int TAG_W  = tag_width(UNIT_W, ROW_W)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    alloc_valid,
    input  logic [ADDR_W-1:0]       alloc_addr,
    input  logic [UNIT_W-1:0]       alloc_unit,
    input  logic [ROW_W-1:0]        alloc_row,
    input  logic                    cmp_valid,
    input  logic [UNIT_W-1:0]       cmp_unit,
    input  logic [ROW_W-1:0]        cmp_row,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD-1:0]        rd_pending,
    output logic [NREAD*UNIT_W-1:0] rd_unit,
    output logic [NREAD*ROW_W-1:0]  rd_row,
    output logic [ADDR_W:0]         pending_count
);

    localparam int CNT_W = ADDR_W + 1;

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_nxt;
    logic [TAG_W-1:0] tag_q [NREGS];
    logic [TAG_W-1:0] alloc_tag;
    logic [TAG_W-1:0] cmp_tag;
    logic [CNT_W-1:0] cnt_nxt;

    assign alloc_tag = {alloc_unit, alloc_row};
    assign cmp_tag   = {cmp_unit, cmp_row};

    // Register 0 never holds a producer.
    assign pend_q[0]   = 1'b0;
    assign pend_nxt[0] = 1'b0;
    assign tag_q[0]    = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_entry
        regstat_entry #(
            .UNIT_W (UNIT_W),
            .ROW_W  (ROW_W),
            .TAG_W  (TAG_W)
        ) u_entry (
            .clock       (clock),
            .reset       (reset),
            .flush       (flush),
            .alloc_hit   (alloc_valid && (alloc_addr == ADDR_W'(i))),
            .alloc_tag   (alloc_tag),
            .cmp_valid   (cmp_valid),
            .cmp_tag     (cmp_tag),
            .pending     (pend_q[i]),
            .pending_nxt (pend_nxt[i]),
            .tag         (tag_q[i])
        );
    end

    logic [ADDR_W-1:0] sel;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_pend;

    // Read muxes, optionally masking a pending entry whose
    // producer is broadcasting in this same cycle.
    always_comb begin
        rd_pending = '0;
        rd_unit    = '0;
        rd_row     = '0;
        sel        = '0;
        sel_tag    = '0;
        sel_pend   = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            sel      = rd_addr[k*ADDR_W +: ADDR_W];
            sel_tag  = tag_q[sel];
            sel_pend = pend_q[sel];
`ifdef REGSTAT_BYPASS_EN
            if (cmp_valid && (sel_tag == cmp_tag)) begin
                sel_pend = 1'b0;
            end
`endif
            rd_pending[k]               = sel_pend;
            rd_unit[k*UNIT_W +: UNIT_W] = sel_tag[ROW_W +: UNIT_W];
            rd_row[k*ROW_W +: ROW_W]    = sel_tag[0 +: ROW_W];
        end
    end

    // Popcount of the table state that the coming edge will load.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
        end
    end

    // Registered pending count tracks the table after each edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_count <= '0;
        end else begin
            pending_count <= cnt_nxt;
        end
    end

endmodule
